vr_tooth_capture: RTL and testbench
===================================

// Module: vr_tooth_capture
// PURPOSE
//  Crank VR input front end; sits directly upstream of the angle generator's capture input.
//  Synchronises and glitch-filters the raw VR comparator pin, then detects rising edges.
//  Measures tooth period in clk cycles, rejects short periods (noise) and flags stalls (timeout).
//  Marks the missing-tooth gap (period > 1.5 x previous) for the angle generator.
// PARAMETERS
//  PW  24  period counter / period output width, bits
//  FW  8   glitch filter length width, bits
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  cap_in     in   1   raw VR comparator pin, asynchronous
//  filt_len   in   FW  filter length; level must differ for filt_len+1 cycles to pass
//  min_per    in   PW  minimum accepted period, cycles
//  max_per    in   PW  maximum period before stall, cycles (>=1)
//  err_clr    in   1   clears noise_flag
//  cap_out    out  1   filtered VR level
//  tooth_stb  out  1   1-cycle pulse: valid tooth period on tooth_per
//  tooth_per  out  PW  last accepted period; held between strobes
//  gap_stb    out  1   1-cycle pulse, coincident with tooth_stb, period is a gap
//  stall_stb  out  1   1-cycle pulse on timeout
//  running    out  1   high in RUN state
//  noise_flag out  1   sticky: an edge was rejected as too short
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sync/filter/counters 0.
//  Sync: 2-FF synchroniser on cap_in -> s.
//  Filter: fcnt <= 0 when s==cap_out; else if fcnt==filt_len: cap_out<=s, fcnt<=0; else fcnt++.
//   Pin-to-cap_out latency = 2 + filt_len + 1 cycles. filt_len=0 -> 3 cycles.
//  Edge: rising edge of cap_out, event in the cycle after cap_out goes 0->1 (registered compare).
//  Period: pcnt counts cycles since last accepted edge; on edge per = pcnt+1 (PW bits); pcnt<=0.
//   pcnt held at 0 in IDLE.
//  States:
//   IDLE : edge -> ARMED, pcnt<=0, no strobe, no min check.
//   ARMED: accepted edge -> RUN, tooth_stb, tooth_per<=per, prev<=per, no gap check.
//   RUN  : accepted edge -> tooth_stb, tooth_per<=per;
//          gap if 2*per > 3*prev (PW+2-bit compare, no overflow): gap_stb, prev unchanged;
//          else prev<=per.
//   ARMED/RUN: edge with per < min_per -> rejected: no strobe, pcnt keeps counting,
//          noise_flag<=1, state unchanged.
//   ARMED/RUN: pcnt==max_per -> timeout: stall_stb, state IDLE, pcnt<=0, running<=0.
//  Simultaneous edge and timeout: timeout wins (stall_stb); the edge is treated as
//   the IDLE first edge -> ARMED (same cycle).
//  noise_flag: set has priority over err_clr in the same cycle.
//  Config inputs sampled live each cycle, no shadowing; change mid-period applies immediately.
//  running = (state==RUN), registered. Reset mid-operation aborts instantly, no strobes emitted.
// TESTING
//  1 Reset asserted mid-run -> all outputs 0 asynchronously, next edge gives no tooth_stb.
//  2 filt_len=3: 3-cycle high pulse on cap_in -> cap_out stays 0; 4-cycle pulse -> cap_out
//    rises 6 cycles after pin rise.
//  3 filt_len=0, min=10, max=1000, edges every 100 cycles -> 1st edge no strobe, 2nd tooth_stb
//    per=100, running=1 after 2nd; tooth_per holds 100.
//  4 Periods 100,100,300,100 -> gap_stb only with per=300; following per=100 no gap (prev=100).
//  5 Edge 5 cycles after accepted edge (min=10) -> no strobe, noise_flag=1; next edge at 100
//    gives per=100; err_clr -> noise_flag=0.
//  6 max=1000, no further edge -> stall_stb when pcnt=1000, running=0; next edge no strobe,
//    edge after 100 more -> tooth_stb per=100.

Source files
------------

// File: rtl/vr_tooth_capture.sv
// Crank VR input front end: synchronise, glitch-filter, detect rising edges,
// measure tooth periods, reject noise, flag stalls and mark the missing-tooth gap.
module vr_tooth_capture #(
    parameter int PW = 24,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap_in,
    input  logic [FW-1:0] filt_len,
    input  logic [PW-1:0] min_per,
    input  logic [PW-1:0] max_per,
    input  logic          err_clr,
    output logic          cap_out,
    output logic          tooth_stb,
    output logic [PW-1:0] tooth_per,
    output logic          gap_stb,
    output logic          stall_stb,
    output logic          running,
    output logic          noise_flag
);

    // state | meaning
    // IDLE  | no reference edge yet; period counter held at 0
    // ARMED | first edge seen, next accepted edge gives the first period
    // RUN   | periods valid; gap detection against previous period active
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic          sync1, sync2;
    logic [FW-1:0] fcnt;
    logic          cap_d;
    logic          edge_evt;

    logic [PW-1:0] pcnt, pcnt_nx;
    logic [PW-1:0] prev, prev_nx;
    logic [PW-1:0] per;
    logic [PW-1:0] tooth_per_nx;
    logic          tooth_stb_nx, gap_stb_nx, stall_stb_nx, noise_nx;
    logic          too_short, timeout, is_gap;
    logic [PW+1:0] per_x2, prev_x3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            fcnt    <= '0;
            cap_out <= 1'b0;
            cap_d   <= 1'b0;
        end else begin
            sync1 <= cap_in;
            sync2 <= sync1;
            cap_d <= cap_out;
            if (sync2 == cap_out) begin
                fcnt <= '0;
            end else if (fcnt == filt_len) begin
                cap_out <= sync2;
                fcnt    <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign edge_evt  = cap_out & ~cap_d;
    assign per       = pcnt + 1'b1;
    assign too_short = (per < min_per);
    assign timeout   = (pcnt == max_per);

    // widened so that 3*prev cannot wrap
    assign per_x2  = {1'b0, per, 1'b0};
    assign prev_x3 = {2'b00, prev} + {1'b0, prev, 1'b0};
    assign is_gap  = (per_x2 > prev_x3);

    always_comb begin
        state_nx     = state;
        pcnt_nx      = pcnt + 1'b1;
        prev_nx      = prev;
        tooth_per_nx = tooth_per;
        tooth_stb_nx = 1'b0;
        gap_stb_nx   = 1'b0;
        stall_stb_nx = 1'b0;
        noise_nx     = noise_flag & ~err_clr;

        case (state)
            IDLE: begin
                pcnt_nx = '0;
                if (edge_evt) begin
                    state_nx = ARMED;
                end
            end
            ARMED, RUN: begin
                if (timeout) begin
                    // a coincident edge restarts the sequence as the first edge
                    stall_stb_nx = 1'b1;
                    pcnt_nx      = '0;
                    state_nx     = edge_evt ? ARMED : IDLE;
                end else if (edge_evt) begin
                    if (too_short) begin
                        noise_nx = 1'b1;
                    end else begin
                        pcnt_nx      = '0;
                        tooth_stb_nx = 1'b1;
                        tooth_per_nx = per;
                        if (state == ARMED) begin
                            state_nx = RUN;
                            prev_nx  = per;
                        end else if (is_gap) begin
                            gap_stb_nx = 1'b1;
                        end else begin
                            prev_nx = per;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                pcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pcnt       <= '0;
            prev       <= '0;
            tooth_per  <= '0;
            tooth_stb  <= 1'b0;
            gap_stb    <= 1'b0;
            stall_stb  <= 1'b0;
            running    <= 1'b0;
            noise_flag <= 1'b0;
        end else begin
            state      <= state_nx;
            pcnt       <= pcnt_nx;
            prev       <= prev_nx;
            tooth_per  <= tooth_per_nx;
            tooth_stb  <= tooth_stb_nx;
            gap_stb    <= gap_stb_nx;
            stall_stb  <= stall_stb_nx;
            running    <= (state_nx == RUN);
            noise_flag <= noise_nx;
        end
    end

endmodule

// File: tb/tb_vr_tooth_capture.sv
// Directed bench for vr_tooth_capture: filter latency, periods, gap, noise, stall, reset.
module tb_vr_tooth_capture;

    localparam int PW = 24;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cap_in;
    logic [FW-1:0] filt_len;
    logic [PW-1:0] min_per;
    logic [PW-1:0] max_per;
    logic          err_clr;
    logic          cap_out;
    logic          tooth_stb;
    logic [PW-1:0] tooth_per;
    logic          gap_stb;
    logic          stall_stb;
    logic          running;
    logic          noise_flag;

    int tests = 0;
    int fails = 0;

    int            n_tooth = 0;
    int            n_gap   = 0;
    int            n_stall = 0;
    logic [PW-1:0] last_per = '0;
    logic          last_gap = 1'b0;

    vr_tooth_capture #(.PW(PW), .FW(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_in    (cap_in),
        .filt_len  (filt_len),
        .min_per   (min_per),
        .max_per   (max_per),
        .err_clr   (err_clr),
        .cap_out   (cap_out),
        .tooth_stb (tooth_stb),
        .tooth_per (tooth_per),
        .gap_stb   (gap_stb),
        .stall_stb (stall_stb),
        .running   (running),
        .noise_flag(noise_flag)
    );

    always #5 clk = ~clk;

    // strobe monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (tooth_stb) begin
                n_tooth  = n_tooth + 1;
                last_per = tooth_per;
                last_gap = gap_stb;
            end
            if (gap_stb)   n_gap   = n_gap + 1;
            if (stall_stb) n_stall = n_stall + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // 2-cycle pin pulse; the next call's pulse starts p cycles later
    task automatic edge_after(input int p);
        cap_in = 1'b1;
        repeat (2) @(negedge clk);
        cap_in = 1'b0;
        repeat (p - 2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({cap_out, tooth_stb, gap_stb, stall_stb, running, noise_flag} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {cap_out, tooth_stb, gap_stb, stall_stb, running, noise_flag});
        end
        tests++;
        if (tooth_per !== '0) begin
            fails++;
            $display("FAIL reset_tooth_per: got %0d expected 0", tooth_per);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_filter();
        logic seen;
        filt_len = 8'd3;
        do_reset();
        cap_in = 1'b1;
        repeat (3) @(negedge clk);
        cap_in = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cap_out) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL filter_short_pulse: cap_out got 1 expected 0");
        end
        cap_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 4) cap_in = 1'b0;
            if (k == 5) begin
                tests++;
                if (cap_out !== 1'b0) begin
                    fails++;
                    $display("FAIL filter_early: cap_out at 5 cycles got %b expected 0", cap_out);
                end
            end
            if (k == 6) begin
                tests++;
                if (cap_out !== 1'b1) begin
                    fails++;
                    $display("FAIL filter_latency: cap_out at 6 cycles got %b expected 1", cap_out);
                end
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_period();
        filt_len = 8'd0;
        min_per  = 24'd10;
        max_per  = 24'd1000;
        do_reset();
        edge_after(100);
        tests++;
        if (n_tooth != 0 || running !== 1'b0) begin
            fails++;
            $display("FAIL first_edge: strobes %0d running %b expected 0 0", n_tooth, running);
        end
        edge_after(100);
        tests++;
        if (n_tooth != 1 || last_per !== 24'd100) begin
            fails++;
            $display("FAIL second_edge: strobes %0d per %0d expected 1 100", n_tooth, last_per);
        end
        tests++;
        if (running !== 1'b1) begin
            fails++;
            $display("FAIL running: got %b expected 1", running);
        end
        edge_after(100);
        tests++;
        if (n_tooth != 2 || tooth_per !== 24'd100 || tooth_stb !== 1'b0) begin
            fails++;
            $display("FAIL per_hold: strobes %0d tooth_per %0d stb %b expected 2 100 0",
                     n_tooth, tooth_per, tooth_stb);
        end
    endtask

    task automatic test_gap();
        int g0;
        g0 = n_gap;
        edge_after(100);
        edge_after(300);
        tests++;
        if (last_per !== 24'd100 || last_gap !== 1'b0) begin
            fails++;
            $display("FAIL gap_pre: per %0d gap %b expected 100 0", last_per, last_gap);
        end
        edge_after(100);
        tests++;
        if (last_per !== 24'd300 || last_gap !== 1'b1 || n_gap != g0 + 1) begin
            fails++;
            $display("FAIL gap_300: per %0d gap %b gaps %0d expected 300 1 %0d",
                     last_per, last_gap, n_gap, g0 + 1);
        end
        edge_after(150);
        tests++;
        if (last_per !== 24'd100 || last_gap !== 1'b0 || n_gap != g0 + 1) begin
            fails++;
            $display("FAIL gap_after: per %0d gap %b gaps %0d expected 100 0 %0d",
                     last_per, last_gap, n_gap, g0 + 1);
        end
        edge_after(100);
        tests++;
        if (last_per !== 24'd150 || last_gap !== 1'b0) begin
            fails++;
            $display("FAIL gap_boundary_150: per %0d gap %b expected 150 0", last_per, last_gap);
        end
    endtask

    task automatic test_noise();
        int t0;
        edge_after(5);
        t0 = n_tooth;
        edge_after(95);
        tests++;
        if (n_tooth != t0 || noise_flag !== 1'b1) begin
            fails++;
            $display("FAIL noise_reject: strobes %0d flag %b expected %0d 1", n_tooth, noise_flag, t0);
        end
        edge_after(100);
        tests++;
        if (n_tooth != t0 + 1 || last_per !== 24'd100 || noise_flag !== 1'b1) begin
            fails++;
            $display("FAIL noise_next: strobes %0d per %0d flag %b expected %0d 100 1",
                     n_tooth, last_per, noise_flag, t0 + 1);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++;
        if (noise_flag !== 1'b0) begin
            fails++;
            $display("FAIL noise_clear: flag %b expected 0", noise_flag);
        end
    endtask

    task automatic test_stall();
        int t0;
        int s0;
        s0 = n_stall;
        edge_after(100);
        repeat (904) @(negedge clk);
        tests++;
        if (stall_stb !== 1'b0 || running !== 1'b1 || n_stall != s0) begin
            fails++;
            $display("FAIL stall_early: stb %b running %b expected 0 1", stall_stb, running);
        end
        @(negedge clk);
        tests++;
        if (stall_stb !== 1'b1 || running !== 1'b0) begin
            fails++;
            $display("FAIL stall_at_max: stb %b running %b expected 1 0", stall_stb, running);
        end
        t0 = n_tooth;
        edge_after(100);
        tests++;
        if (n_tooth != t0) begin
            fails++;
            $display("FAIL stall_rearm: strobes %0d expected %0d", n_tooth, t0);
        end
        edge_after(100);
        tests++;
        if (n_tooth != t0 + 1 || last_per !== 24'd100 || running !== 1'b1) begin
            fails++;
            $display("FAIL stall_recover: strobes %0d per %0d running %b expected %0d 100 1",
                     n_tooth, last_per, running, t0 + 1);
        end
    endtask

    task automatic test_reset_midrun();
        int t0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cap_out, tooth_stb, gap_stb, stall_stb, running, noise_flag} !== 6'b0 ||
            tooth_per !== '0) begin
            fails++;
            $display("FAIL midrun_reset: flags %b tooth_per %0d expected 000000 0",
                     {cap_out, tooth_stb, gap_stb, stall_stb, running, noise_flag}, tooth_per);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t0 = n_tooth;
        edge_after(100);
        tests++;
        if (n_tooth != t0 || running !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_edge: strobes %0d running %b expected %0d 0",
                     n_tooth, running, t0);
        end
        edge_after(100);
        tests++;
        if (n_tooth != t0 + 1 || last_per !== 24'd100) begin
            fails++;
            $display("FAIL post_reset_period: strobes %0d per %0d expected %0d 100",
                     n_tooth, last_per, t0 + 1);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cap_in   = 1'b0;
        filt_len = 8'd0;
        min_per  = 24'd10;
        max_per  = 24'd1000;
        err_clr  = 1'b0;
        test_reset();
        test_filter();
        test_period();
        test_gap();
        test_noise();
        test_stall();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
